// File: rtl/mem_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one memory stream controller among NUM_REQ requesters.
// Define MEMARB_RR_EN for round-robin selection; otherwise lowest index wins.
module mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int LEN_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           IN_req,
  input  logic [NUM_REQ-1:0]           IN_reqWrite,
  input  logic [NUM_REQ*LEN_BITS-1:0]  IN_reqLen,
  input  logic [NUM_REQ*30-1:0]        IN_reqAddr,
  input  logic [NUM_REQ*32-1:0]        IN_wdata,
  output logic [NUM_REQ-1:0]           OUT_grant,
  output logic [NUM_REQ-1:0]           OUT_owner,
  output logic [NUM_REQ-1:0]           OUT_advance,
  output logic [31:0]                  OUT_rdata,
  output logic                         OUT_MEM_en,
  output logic                         OUT_MEM_write,
  output logic [LEN_BITS-1:0]          OUT_MEM_len,
  output logic [29:0]                  OUT_MEM_addr,
  input  logic                         IN_MEM_busy,
  input  logic                         IN_MEM_advance,
  input  logic [31:0]                  IN_MEM_data,
  output logic [31:0]                  OUT_MEM_wdata
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, owner_q, owner_d;
  logic                 en_q, en_d, write_q, write_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [29:0]          addr_q, addr_d;
  logic                 win_vld;
  logic [PW-1:0]        win_idx;

`ifdef MEMARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Walk from the pointer upward; descending k so the nearest request wins.
  always_comb begin : rr_sel
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (IN_req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (IN_req[k]) begin
        win_vld = 1'b1;
        win_idx = PW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    owner_d = owner_q;
    en_d    = 1'b0;
    write_d = write_q;
    len_d   = len_q;
    addr_d  = addr_q;
`ifdef MEMARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld && !IN_MEM_busy) begin
          grant_d[win_idx] = 1'b1;
`ifdef MEMARB_RR_EN
          ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
`endif
          // Zero-length requests are acknowledged without touching the memory side.
          if (IN_reqLen[win_idx*LEN_BITS +: LEN_BITS] != '0) begin
            owner_d          = '0;
            owner_d[win_idx] = 1'b1;
            en_d             = 1'b1;
            write_d          = IN_reqWrite[win_idx];
            len_d            = IN_reqLen[win_idx*LEN_BITS +: LEN_BITS];
            addr_d           = IN_reqAddr[win_idx*30 +: 30];
            state_d          = ISSUE;
          end
        end
      end
      ISSUE: state_d = XFER;
      XFER: begin
        if (!IN_MEM_busy) begin
          owner_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
`ifdef MEMARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      write_q <= write_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
`ifdef MEMARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Owner clears one edge after busy falls, so the last advance still routes.
  always_comb begin
    OUT_MEM_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner_q[i]) OUT_MEM_wdata = OUT_MEM_wdata | IN_wdata[i*32 +: 32];
  end

  assign OUT_advance   = {NUM_REQ{IN_MEM_advance}} & owner_q;
  assign OUT_rdata     = IN_MEM_data;
  assign OUT_grant     = grant_q;
  assign OUT_owner     = owner_q;
  assign OUT_MEM_en    = en_q;
  assign OUT_MEM_write = write_q;
  assign OUT_MEM_len   = len_q;
  assign OUT_MEM_addr  = addr_q;
endmodule
